// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Load/store initiator for a byte-addressable, synchronous-read RAM.
//   It accepts one request at a time. Out-of-range or disallowed accesses are
//   answered with an error and never touch the RAM. Stores pulse the write
//   enable for a single cycle. Loads present the address for two cycles,
//   capture the read data, and then sign- or zero-extend it.
//
// Ports
//   i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//   i_req_*/o_req_ready   request channel (valid/ready)
//   o_rsp_*/i_rsp_ready   response channel (valid/ready); rdata is 0 for
//                         stores and errors
//   o_mem_*/i_mem_rdata   RAM port; mask and data are unrotated, and the
//                         addressed byte returns in i_mem_rdata[7:0]

module lsu_mem_master #(
    parameter int DEPTH            = 4096,
    parameter bit ALLOW_MISALIGNED = 1'b1,
    localparam int ADDR_W          = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_bmask,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_STORE     = 3'd1;
    localparam logic [2:0] S_LOAD_ADDR = 3'd2;
    localparam logic [2:0] S_LOAD_DATA = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    // Request checks, evaluated on the incoming fields at accept time.
    logic [2:0]        last_off;
    logic [ADDR_W:0]   last_byte;
    logic              misaligned;
    logic              req_err;
    logic [31:0]       keep_mask;
    logic [31:0]       load_ext;

    always_comb begin
        last_off  = 3'd0;
        keep_mask = 32'h0000_00FF;
        case (i_req_size)
            2'b00:   begin last_off = 3'd0; keep_mask = 32'h0000_00FF; end
            2'b01:   begin last_off = 3'd1; keep_mask = 32'h0000_FFFF; end
            default: begin last_off = 3'd3; keep_mask = 32'hFFFF_FFFF; end
        endcase
    end

    // A carry into bit ADDR_W means the access would run past the top of the RAM.
    assign last_byte  = {1'b0, i_req_addr[ADDR_W-1:0]} + {{(ADDR_W-2){1'b0}}, last_off};
    assign misaligned = ((i_req_size == 2'b01) && i_req_addr[0])
                     || ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));
    assign req_err    = (i_req_size == 2'b11)
                     || (i_req_addr[31:ADDR_W] != '0)
                     || last_byte[ADDR_W]
                     || (!ALLOW_MISALIGNED && misaligned);

    always_comb begin
        load_ext = i_mem_rdata;
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & i_mem_rdata[7]}},  i_mem_rdata[7:0]};
            2'b01:   load_ext = {{16{~uns_q & i_mem_rdata[15]}}, i_mem_rdata[15:0]};
            default: load_ext = i_mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    addr_d  = i_req_addr[ADDR_W-1:0];
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    wdata_d = i_req_we ? (i_req_wdata & keep_mask) : '0;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_err)       state_d = S_RESP;
                    else if (i_req_we) state_d = S_STORE;
                    else               state_d = S_LOAD_ADDR;
                end
            end
            S_STORE:     state_d = S_RESP;
            S_LOAD_ADDR: state_d = S_LOAD_DATA;
            S_LOAD_DATA: begin
                // The RAM data for the held address is valid in this cycle.
                rdata_d = load_ext;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (i_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_rsp_valid = (state_q == S_RESP);
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wren  = (state_q == S_STORE);

    always_comb begin
        o_mem_bmask = 4'b0000;
        if (state_q == S_STORE) begin
            case (size_q)
                2'b00:   o_mem_bmask = 4'b0001;
                2'b01:   o_mem_bmask = 4'b0011;
                default: o_mem_bmask = 4'b1111;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master
//   Drives two instances (misaligned allowed / disallowed) that share one
//   behavioural RAM. Expected results come from a byte-array reference
//   model that applies the access rules directly.

module tb_lsu_mem_master;

    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [1:0]  req_size  = 2'b00;
    logic        req_uns   = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b1;
    bit          sel       = 1'b0;

    logic          vld_a, vld_b, rdy_a, rdy_b, rv_a, rv_b, err_a, err_b, wren_a, wren_b;
    logic [31:0]   rdata_a, rdata_b, mwd_a, mwd_b;
    logic [31:0]   mrd_a = '0;
    logic [31:0]   mrd_b = '0;
    logic [AW-1:0] maddr_a, maddr_b;
    logic [3:0]    bm_a, bm_b;

    assign vld_a = req_valid && !sel;
    assign vld_b = req_valid && sel;

    lsu_mem_master #(.DEPTH(DEPTH), .ALLOW_MISALIGNED(1'b1)) u_dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(vld_a), .o_req_ready(rdy_a), .i_req_we(req_we),
        .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_rsp_valid(rv_a), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rdata_a), .o_rsp_err(err_a), .o_mem_addr(maddr_a),
        .o_mem_bmask(bm_a), .o_mem_wdata(mwd_a), .o_mem_wren(wren_a),
        .i_mem_rdata(mrd_a)
    );

    lsu_mem_master #(.DEPTH(DEPTH), .ALLOW_MISALIGNED(1'b0)) u_dut_strict (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(vld_b), .o_req_ready(rdy_b), .i_req_we(req_we),
        .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_rsp_valid(rv_b), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rdata_b), .o_rsp_err(err_b), .o_mem_addr(maddr_b),
        .o_mem_bmask(bm_b), .o_mem_wdata(mwd_b), .o_mem_wren(wren_b),
        .i_mem_rdata(mrd_b)
    );

    // Outputs of whichever instance the current transaction targets.
    logic          rdy, rv, err, wren;
    logic [31:0]   rdata, mwd;
    logic [AW-1:0] maddr;
    logic [3:0]    bm;
    assign rdy   = sel ? rdy_b   : rdy_a;
    assign rv    = sel ? rv_b    : rv_a;
    assign err   = sel ? err_b   : err_a;
    assign wren  = sel ? wren_b  : wren_a;
    assign rdata = sel ? rdata_b : rdata_a;
    assign mwd   = sel ? mwd_b   : mwd_a;
    assign maddr = sel ? maddr_b : maddr_a;
    assign bm    = sel ? bm_b    : bm_a;

    // Shared RAM: unrotated mask/data; addressed byte returned in [7:0].
    byte unsigned ram [DEPTH];
    byte unsigned ref_mem [DEPTH];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wren_a && bm_a[k]) ram[maddr_a + AW'(k)] <= mwd_a[8*k +: 8];
            if (wren_b && bm_b[k]) ram[maddr_b + AW'(k)] <= mwd_b[8*k +: 8];
        end
        mrd_a <= {ram[maddr_a + 12'd3], ram[maddr_a + 12'd2], ram[maddr_a + 12'd1], ram[maddr_a]};
        mrd_b <= {ram[maddr_b + 12'd3], ram[maddr_b + 12'd2], ram[maddr_b + 12'd1], ram[maddr_b]};
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // Reference model: decides error, applies stores and returns the extended load value.
    task automatic model(input bit strict, input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output bit exp_err, output logic [31:0] exp_rd);
        longint unsigned a;
        longint unsigned v;
        int n;
        a = addr;
        n = nbytes(size);
        exp_err = (size == 2'b11) || (a + longint'(n) > longint'(DEPTH))
                  || (strict && (a % longint'(n) != 0));
        exp_rd = '0;
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wdata[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[int'(a) + i]) << (8*i));
                if (!uns && v[8*n-1]) v = v - (64'd1 << (8*n));
                exp_rd = v[31:0];
            end
        end
    endtask

    task automatic xact(input bit s, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        bit            exp_err;
        logic [31:0]   exp_rd;
        logic [63:0]   full;
        int            n, lat, wren_cnt, rsp_cyc;
        model(s, we, size, uns, addr, wdata, exp_err, exp_rd);
        n    = nbytes(size);
        lat  = exp_err ? 1 : (we ? 2 : 3);
        full = (64'd1 << (8*n)) - 64'd1;

        @(negedge clk);
        sel = s;
        check("req_ready_idle", {31'd0, rdy}, 32'd1);
        req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        rsp_ready = (stall == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;

        wren_cnt = 0;
        rsp_cyc  = 0;
        for (int c = 1; c <= 8 && rsp_cyc == 0; c++) begin
            @(negedge clk);
            if (wren) begin
                wren_cnt++;
                check("wren_cycle", c, 1);
                check("mem_bmask", {28'd0, bm}, 32'((1 << n) - 1));
                check("mem_wdata", mwd, wdata & full[31:0]);
                check("mem_addr_store", {20'd0, maddr}, {20'd0, addr[AW-1:0]});
            end
            if (!we && !exp_err && c <= 2)
                check("mem_addr_load", {20'd0, maddr}, {20'd0, addr[AW-1:0]});
            if (rv) rsp_cyc = c;
        end
        check("rsp_cycle", rsp_cyc, lat);
        if (rsp_cyc != 0) begin
            check("rsp_rdata", rdata, exp_rd);
            check("rsp_err", {31'd0, err}, {31'd0, exp_err});
            if (stall > 0) begin
                // A competing store request must be ignored while the response is held.
                req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10;
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    if (wren) wren_cnt++;
                    check("stall_valid", {31'd0, rv}, 32'd1);
                    check("stall_rdata", rdata, exp_rd);
                    check("stall_err", {31'd0, err}, {31'd0, exp_err});
                    check("stall_addr", {20'd0, maddr}, {20'd0, addr[AW-1:0]});
                    check("stall_req_ready", {31'd0, rdy}, 32'd0);
                end
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            check("back_to_idle", {31'd0, rdy}, 32'd1);
            check("rsp_dropped", {31'd0, rv}, 32'd0);
        end
        check("wren_count", wren_cnt, (!exp_err && we) ? 1 : 0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, rdy_a}, 32'd1);
        check({tag, "_rv"},    {31'd0, rv_a},  32'd0);
        check({tag, "_rdata"}, rdata_a, 32'd0);
        check({tag, "_err"},   {31'd0, err_a}, 32'd0);
        check({tag, "_addr"},  {20'd0, maddr_a}, 32'd0);
        check({tag, "_bmask"}, {28'd0, bm_a}, 32'd0);
        check({tag, "_wdata"}, mwd_a, 32'd0);
        check({tag, "_wren"},  {31'd0, wren_a}, 32'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        xact(0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0);
        xact(0, 0, 2'b10, 0, 32'h100, 32'h0, 0);
        xact(0, 1, 2'b00, 0, 32'h103, 32'hFFFFFF80, 0);
        xact(0, 0, 2'b00, 0, 32'h103, 32'h0, 0);
        xact(0, 0, 2'b00, 1, 32'h103, 32'h0, 0);
        xact(0, 1, 2'b01, 0, 32'h102, 32'hABCD8001, 0);
        xact(0, 0, 2'b01, 0, 32'h102, 32'h0, 0);
        xact(0, 0, 2'b01, 1, 32'h102, 32'h0, 0);
        xact(0, 1, 2'b10, 0, 32'h101, 32'h12345678, 0);
        xact(0, 0, 2'b10, 0, 32'h101, 32'h0, 0);
        xact(1, 1, 2'b10, 0, 32'h101, 32'h12345678, 0);
        xact(1, 0, 2'b01, 0, 32'h103, 32'h0, 0);
        xact(0, 0, 2'b10, 0, 32'h00000FFE, 32'h0, 0);
        xact(0, 0, 2'b00, 0, 32'h00001000, 32'h0, 0);
        xact(0, 1, 2'b11, 0, 32'h00000010, 32'h55AA55AA, 0);
        xact(0, 1, 2'b10, 0, 32'h00000FFC, 32'hCAFEF00D, 0);
        xact(0, 0, 2'b10, 0, 32'h00000FFC, 32'h0, 0);
        xact(0, 0, 2'b10, 0, 32'h100, 32'h0, 5);

        // Asynchronous reset while the load sits in LOAD_DATA
        @(negedge clk);
        sel = 1'b0;
        req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0; req_addr = 32'h100;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        xact(0, 0, 2'b10, 0, 32'h0, 32'h0, 0);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            logic [31:0] addr;
            logic [1:0]  size;
            int          r, stall;
            r = $urandom_range(0, 9);
            if (r <= 5)      addr = $urandom_range(0, 63);
            else if (r <= 7) addr = DEPTH - 8 + $urandom_range(0, 7);
            else if (r == 8) addr = $urandom;
            else             addr = DEPTH + $urandom_range(0, 3);
            size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            stall = ($urandom_range(0, 9) < 2) ? $urandom_range(1, 3) : 0;
            xact(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), size,
                 1'($urandom_range(0, 1)), addr, $urandom, stall);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that drives the byte-addressable synchronous-read RAM port (address, byte mask, write data, write enable, read data) on behalf of the core's memory stage. It accepts one load or store request over a valid/ready handshake and sequences the RAM access, including the extra cycle a synchronous read needs. It extracts and sign- or zero-extends the loaded byte, halfword or word, and returns one response per request over a second valid/ready handshake. Misaligned accesses are passed to the RAM, which resolves them internally. Out-of-range and disallowed accesses are answered with an error and never touch memory.

## Interface
- DEPTH, 4096, RAM size in bytes; power of two, ≥16; ADDR_W = $clog2(DEPTH)
- ALLOW_MISALIGNED, 1, 1 = misaligned half/word passed to RAM; 0 = flagged as error

- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid & ready
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_req_unsigned  in  1  load zero-extend (1) / sign-extend (0)
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-justified
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed when valid & ready
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  access fault
- o_mem_addr  out  ADDR_W  RAM byte address
- o_mem_bmask  out  4  RAM byte mask, unrotated (RAM rotates internally)
- o_mem_wdata  out  32  RAM write data, unrotated
- o_mem_wren  out  1  RAM write enable
- i_mem_rdata  in  32  RAM read data; the addressed byte is in [7:0]; valid the cycle after the address, with the address held

## Operation
- FSM states: IDLE, STORE, LOAD_ADDR, LOAD_DATA, RESP.
- IDLE: o_req_ready=1. On accept, register addr[ADDR_W-1:0], size, unsigned, we and wdata, then evaluate the error conditions.
- Error conditions (any one sets err):
  - size==11
  - addr[31:ADDR_W]!=0
  - addr[ADDR_W-1:0] + nbytes − 1 exceeds DEPTH−1 (no wrap past the top); nbytes = 1/2/4
  - ALLOW_MISALIGNED=0 and (half with addr[0]!=0, or word with addr[1:0]!=0)
- On error: go to RESP with err=1, rdata=0. No RAM access; o_mem_wren is never asserted.
- Store: go to STORE. o_mem_wren=1 for exactly one cycle. o_mem_bmask = 0001/0011/1111 for byte/half/word. o_mem_wdata = wdata with unused upper bytes zeroed. Then go to RESP with rdata=0.
- Load: LOAD_ADDR drives the address (wren=0) → LOAD_DATA captures i_mem_rdata at end of cycle → RESP.
- Load extension:
  - byte: {24×(~unsigned & d[7]), d[7:0]}
  - half: {16×(~unsigned & d[15]), d[15:0]}
  - word: d
- RESP: o_rsp_valid=1 with rdata/err stable until i_rsp_ready. On handshake go to IDLE. o_req_ready=0 in all states except IDLE.
- o_mem_addr is updated only on accept and is held constant through LOAD_DATA and RESP.
- o_mem_bmask=0 and o_mem_wren=0 outside STORE.

## Timing
- Reset (asynchronous, immediate): state=IDLE; o_req_ready=1; o_rsp_valid=0; o_rsp_rdata=0; o_rsp_err=0; o_mem_addr=0; o_mem_bmask=0; o_mem_wdata=0; o_mem_wren=0.
- Reset mid-operation discards the pending request. A write in progress is dropped the same instant wren deasserts.
- Accept at cycle 0 gives:
  - store: wren high in cycle 1, o_rsp_valid in cycle 2
  - load: address presented in cycles 1–2, data sampled at end of cycle 2, o_rsp_valid in cycle 3
  - error: o_rsp_valid in cycle 1
- Minimum request-to-request spacing: 2 (error), 3 (store), 4 (load) cycles with i_rsp_ready tied high.
- No overlap: a request cannot be accepted in the cycle its predecessor's response handshakes.
- i_req_* are ignored when o_req_ready=0.

## Test plan
- Reset asserted mid-LOAD_DATA → all outputs return to reset values asynchronously. A following word load at 0x000 completes normally with rsp at cycle 3.
- Store word 0xDEADBEEF @0x100 → bmask 1111 and wren for exactly cycle 1, rsp cycle 2 with rdata=0, err=0. Load word @0x100 → rdata 0xDEADBEEF at cycle 3.
- Store byte 0x80 @0x103 → bmask 0001, wdata 0x00000080. Signed byte load @0x103 → 0xFFFFFF80; unsigned → 0x00000080. Signed half load @0x102 after storing half 0x8001 there → 0xFFFF8001.
- With ALLOW_MISALIGNED=1, store word 0x12345678 @0x101 then load word @0x101 → 0x12345678. With ALLOW_MISALIGNED=0, the same store → err=1 at cycle 1 and wren never high.
- Word load @0x00000FFE (DEPTH=4096), byte load @0x00001000, and size=11 → each returns err=1, rdata=0, rsp cycle 1, no RAM write.
- Load with i_rsp_ready held low 5 cycles → o_rsp_valid, rdata and o_mem_addr stable, o_req_ready=0, and a concurrent i_req_valid is ignored. Release i_rsp_ready → IDLE next cycle.
